mmd_dsm_ctrl: RTL and testbench

Fractional-N divide-ratio generator that drives the `DIVNUM` input of the 5-stage multi-modulus divider (4~63 range). It runs in the divided-clock domain: it updates one divide ratio per `CKVD` period, and the MMD retimes that ratio on its next `CKVD` rising edge. A 3rd-order MASH 1-1-1 delta-sigma modulator dithers the integer ratio so that the long-term average division equals `NINT + NFRAC/2^FRAC_W`. The output is clamped to the MMD's legal range.

---
 rtl/mmd_dsm_ctrl.sv | 172 +++++++++++++++++
 tb/tb_mmd_dsm_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmd_dsm_ctrl.sv
// -----------------------------------------------------------------------------
// mmd_dsm_ctrl
//
// Fractional-N divide-ratio generator for a 5-stage multi-modulus divider
// (MMD, legal ratios NMIN..NMAX). It runs in the divided-clock domain and
// produces one registered ratio per CKVD period. A 3rd-order MASH 1-1-1
// delta-sigma modulator dithers the integer ratio, so the long-term average
// division equals NINT + NFRAC/2^FRAC_W. The result is clamped to the legal
// MMD range, and SAT flags the cycles in which clamping took place.
//
// Optional feature (compile-time macro MMD_DSM_DITHER_EN):
//   When defined, a 16-bit Fibonacci LFSR (taps 16,14,13,11, seed 16'hACE1)
//   advances every cycle and its bit 0 is added at the LSB of the first
//   accumulator while the modulator is enabled. This breaks up idle tones
//   for rational NFRAC. When undefined the modulator is fully deterministic.
//
// Parameters:
//   FRAC_W  fractional word / accumulator width (default 16)
//   NMIN    minimum legal divide ratio        (default 4)
//   NMAX    maximum legal divide ratio        (default 63)
//
// Ports:
//   CKVD    in   1        divided clock from the MMD, rising edge active
//   RST     in   1        synchronous active-high reset
//   NINT    in   6        integer divide ratio, unsigned
//   NFRAC   in   FRAC_W   fractional word, units of 2^-FRAC_W
//   DSM_EN  in   1        1 = fractional mode, 0 = integer mode
//   DIVNUM  out  6        registered divide ratio to the MMD
//   SAT     out  1        registered flag, high while DIVNUM is clamped
// -----------------------------------------------------------------------------
module mmd_dsm_ctrl #(
   parameter int FRAC_W = 16,
   parameter int NMIN   = 4,
   parameter int NMAX   = 63
) (
   input  logic              CKVD,
   input  logic              RST,
   input  logic [5:0]        NINT,
   input  logic [FRAC_W-1:0] NFRAC,
   input  logic              DSM_EN,
   output logic [5:0]        DIVNUM,
   output logic              SAT
);

   localparam logic signed [7:0] NMIN_S = 8'(NMIN);
   localparam logic signed [7:0] NMAX_S = 8'(NMAX);

   // Registered copies of the inputs; the modulator only sees these.
   logic [5:0]        nint_q,  nint_d;
   logic [FRAC_W-1:0] nfrac_q, nfrac_d;
   logic              en_q,    en_d;

   // MASH accumulators and carry delay line.
   logic [FRAC_W-1:0] acc1_q, acc1_d;
   logic [FRAC_W-1:0] acc2_q, acc2_d;
   logic [FRAC_W-1:0] acc3_q, acc3_d;
   logic              c2_d1_q, c2_d1_d;
   logic              c3_d1_q, c3_d1_d;
   logic              c3_d2_q, c3_d2_d;

   // Output registers.
   logic [5:0]        divnum_q, divnum_d;
   logic              sat_q,    sat_d;

   // Combinational datapath.
   logic [FRAC_W:0]   s1, s2, s3;
   logic              c1, c2, c3;
   logic signed [3:0] delta;
   logic signed [7:0] sum;
   logic              below_min, above_max;

`ifdef MMD_DSM_DITHER_EN
   logic [15:0]       lfsr_q, lfsr_d;
   logic              dither;
`endif

   // NOTE: every signal assigned in an always_comb gets a value on every path
   // (defaults first), otherwise synthesis infers a latch.
   always_comb begin
      nint_d  = NINT;
      nfrac_d = NFRAC;
      en_d    = DSM_EN;

`ifdef MMD_DSM_DITHER_EN
      // Fibonacci LFSR, x^16 + x^14 + x^13 + x^11 + 1.
      lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      dither = lfsr_q[0] & en_q;
      s1     = {1'b0, acc1_q} + {1'b0, nfrac_q} + {{FRAC_W{1'b0}}, dither};
`else
      s1     = {1'b0, acc1_q} + {1'b0, nfrac_q};
`endif
      // Stage 2 and 3 integrate the (wrapped) output of the stage before.
      s2 = {1'b0, acc2_q} + {1'b0, s1[FRAC_W-1:0]};
      s3 = {1'b0, acc3_q} + {1'b0, s2[FRAC_W-1:0]};
      c1 = s1[FRAC_W];
      c2 = s2[FRAC_W];
      c3 = s3[FRAC_W];

      acc1_d  = '0;
      acc2_d  = '0;
      acc3_d  = '0;
      c2_d1_d = 1'b0;
      c3_d1_d = 1'b0;
      c3_d2_d = 1'b0;
      delta   = '0;

      if (en_q) begin
         acc1_d  = s1[FRAC_W-1:0];
         acc2_d  = s2[FRAC_W-1:0];
         acc3_d  = s3[FRAC_W-1:0];
         c2_d1_d = c2;
         c3_d1_d = c3;
         c3_d2_d = c3_d1_q;
         // c1 + (1-z^-1)c2 + (1-z^-1)^2 c3; 4-bit modular arithmetic is exact
         // because the true result always lies in -3..+4.
         delta = 4'(c1) + 4'(c2) - 4'(c2_d1_q) + 4'(c3)
               - {2'b00, c3_d1_q, 1'b0} + 4'(c3_d2_q);
      end

      sum       = {2'b00, nint_q} + {{4{delta[3]}}, delta};
      below_min = (sum < NMIN_S);
      above_max = (sum > NMAX_S);
      sat_d     = below_min | above_max;
      if (below_min) begin
         divnum_d = NMIN_S[5:0];
      end else if (above_max) begin
         divnum_d = NMAX_S[5:0];
      end else begin
         divnum_d = sum[5:0];
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the values from before the edge, independent of statement order.
   always_ff @(posedge CKVD) begin
      if (RST) begin
         nint_q   <= '0;
         nfrac_q  <= '0;
         en_q     <= 1'b0;
         acc1_q   <= '0;
         acc2_q   <= '0;
         acc3_q   <= '0;
         c2_d1_q  <= 1'b0;
         c3_d1_q  <= 1'b0;
         c3_d2_q  <= 1'b0;
         divnum_q <= NMIN_S[5:0];
         sat_q    <= 1'b0;
`ifdef MMD_DSM_DITHER_EN
         lfsr_q   <= 16'hACE1;
`endif
      end else begin
         nint_q   <= nint_d;
         nfrac_q  <= nfrac_d;
         en_q     <= en_d;
         acc1_q   <= acc1_d;
         acc2_q   <= acc2_d;
         acc3_q   <= acc3_d;
         c2_d1_q  <= c2_d1_d;
         c3_d1_q  <= c3_d1_d;
         c3_d2_q  <= c3_d2_d;
         divnum_q <= divnum_d;
         sat_q    <= sat_d;
`ifdef MMD_DSM_DITHER_EN
         lfsr_q   <= lfsr_d;
`endif
      end
   end

   assign DIVNUM = divnum_q;
   assign SAT    = sat_q;

endmodule

// File: tb/tb_mmd_dsm_ctrl.sv
// -----------------------------------------------------------------------------
// Self-checking bench for mmd_dsm_ctrl. Directed scenarios with hand-derived
// expected ratio sequences; outputs are sampled 1 ns after the rising edge.
// With MMD_DSM_DITHER_EN defined the half-fraction test checks the mean and
// that the sequence departs from the deterministic pattern.
// -----------------------------------------------------------------------------
module tb_mmd_dsm_ctrl;

   localparam int FRAC_W = 16;

   logic              CKVD = 1'b0;
   logic              RST;
   logic [5:0]        NINT;
   logic [FRAC_W-1:0] NFRAC;
   logic              DSM_EN;
   logic [5:0]        DIVNUM;
   logic              SAT;

   int n_tests = 0;
   int n_fail  = 0;

   // Deterministic MASH output for NINT = 20 starting from a zeroed state.
   int exp_quarter [8] = '{20, 21, 19, 22, 18, 23, 18, 21}; // NFRAC = 1/4
   int exp_half    [4] = '{20, 22, 19, 21};                 // NFRAC = 1/2

   mmd_dsm_ctrl #(.FRAC_W(FRAC_W), .NMIN(4), .NMAX(63)) dut (
      .CKVD   (CKVD),
      .RST    (RST),
      .NINT   (NINT),
      .NFRAC  (NFRAC),
      .DSM_EN (DSM_EN),
      .DIVNUM (DIVNUM),
      .SAT    (SAT)
   );

   always #5 CKVD = ~CKVD;

   task automatic tick();
      @(posedge CKVD);
      #1;
   endtask

   // Leave fractional mode long enough that nint_q holds NINT and the
   // modulator state has been forced to zero.
   task automatic go_integer(input int nint);
      DSM_EN = 1'b0;
      NINT   = 6'(nint);
      tick();
      tick();
   endtask

   task automatic test_reset();
      RST = 1'b1; NINT = 6'd20; NFRAC = '0; DSM_EN = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_tests++;
         if (DIVNUM !== 6'd4 || SAT !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hold[%0d]: DIVNUM=%0d SAT=%b, want 4/0", i, DIVNUM, SAT);
         end
      end
      RST = 1'b0;
      tick();
      // nint_q still holds its reset value 0, which clamps to NMIN with SAT.
      n_tests++;
      if (DIVNUM !== 6'd4 || SAT !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_rel1: DIVNUM=%0d SAT=%b, want 4/1", DIVNUM, SAT);
      end
      tick();
      n_tests++;
      if (DIVNUM !== 6'd20 || SAT !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_rel2: DIVNUM=%0d SAT=%b, want 20/0", DIVNUM, SAT);
      end
   endtask

   task automatic test_integer();
      int bad;
      DSM_EN = 1'b0; NINT = 6'd20; NFRAC = 16'h8000;
      tick();
      bad = 0;
      for (int i = 0; i < 1000; i++) begin
         tick();
         if (DIVNUM !== 6'd20 || SAT !== 1'b0) bad++;
      end
      n_tests++;
      if (bad != 0) begin
         n_fail++;
         $display("FAIL integer_const: %0d bad cycles (last DIVNUM=%0d SAT=%b), want 0", bad, DIVNUM, SAT);
      end

      // Out-of-range integer ratios clamp and hold SAT.
      NINT = 6'd2;
      tick(); tick();
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         if (DIVNUM !== 6'd4 || SAT !== 1'b1) bad++;
         tick();
      end
      n_tests++;
      if (bad != 0) begin
         n_fail++;
         $display("FAIL integer_low_clamp: %0d bad cycles (DIVNUM=%0d SAT=%b), want 4/1", bad, DIVNUM, SAT);
      end

      NINT = 6'd63;
      tick(); tick();
      n_tests++;
      if (DIVNUM !== 6'd63 || SAT !== 1'b0) begin
         n_fail++;
         $display("FAIL integer_max: DIVNUM=%0d SAT=%b, want 63/0", DIVNUM, SAT);
      end

      NINT = 6'd0;
      tick(); tick();
      n_tests++;
      if (DIVNUM !== 6'd4 || SAT !== 1'b1) begin
         n_fail++;
         $display("FAIL integer_zero: DIVNUM=%0d SAT=%b, want 4/1", DIVNUM, SAT);
      end
   endtask

   task automatic test_frac_mean();
      int sum, bad_seq, bad_rng;
      go_integer(20);
      DSM_EN = 1'b1; NFRAC = 16'h4000;
      tick();
      sum = 0; bad_seq = 0; bad_rng = 0;
      for (int i = 0; i < 4096; i++) begin
         tick();
         sum += int'(DIVNUM);
         if (DIVNUM < 6'd17 || DIVNUM > 6'd24 || SAT !== 1'b0) bad_rng++;
         if (int'(DIVNUM) != exp_quarter[i % 8]) bad_seq++;
         if (i < 8) begin
            n_tests++;
            if (int'(DIVNUM) != exp_quarter[i]) begin
               n_fail++;
               $display("FAIL frac_seq[%0d]: DIVNUM=%0d, want %0d", i, DIVNUM, exp_quarter[i]);
            end
         end
      end
      n_tests++;
      if (bad_rng != 0) begin
         n_fail++;
         $display("FAIL frac_range: %0d cycles outside 17..24 or SAT set, want 0", bad_rng);
      end
      n_tests++;
      if (bad_seq != 0) begin
         n_fail++;
         $display("FAIL frac_periodic: %0d cycles off the period-8 pattern, want 0", bad_seq);
      end
      n_tests++;
      if (sum < 82941 || sum > 82947) begin
         n_fail++;
         $display("FAIL frac_sum: sum=%0d, want 82944 +/- 3", sum);
      end
   endtask

   task automatic test_nfrac_zero();
      int bad;
      go_integer(37);
      DSM_EN = 1'b1; NFRAC = '0;
      tick();
      bad = 0;
      for (int i = 0; i < 50; i++) begin
         tick();
         if (DIVNUM !== 6'd37 || SAT !== 1'b0) bad++;
      end
      n_tests++;
      if (bad != 0) begin
         n_fail++;
         $display("FAIL nfrac_zero: %0d bad cycles (DIVNUM=%0d), want 37 constant", bad, DIVNUM);
      end
   endtask

   task automatic test_low_sat();
      int exp_div [3] = '{4, 7, 4};
      logic exp_sat [3] = '{1'b0, 1'b0, 1'b1};
      int sat_cnt, bad;
      go_integer(4);
      DSM_EN = 1'b1; NFRAC = 16'hC000;
      tick();
      sat_cnt = 0; bad = 0;
      for (int i = 0; i < 2000; i++) begin
         tick();
         if (SAT === 1'b1) sat_cnt++;
         if (DIVNUM < 6'd4 || DIVNUM > 6'd8) bad++;
         if (SAT === 1'b1 && DIVNUM !== 6'd4) bad++;
         if (i < 3) begin
            n_tests++;
            if (int'(DIVNUM) != exp_div[i] || SAT !== exp_sat[i]) begin
               n_fail++;
               $display("FAIL low_sat_seq[%0d]: DIVNUM=%0d SAT=%b, want %0d/%b",
                        i, DIVNUM, SAT, exp_div[i], exp_sat[i]);
            end
         end
      end
      n_tests++;
      if (bad != 0) begin
         n_fail++;
         $display("FAIL low_sat_range: %0d bad cycles, want DIVNUM in 4..8 and SAT only at 4", bad);
      end
      n_tests++;
      if (sat_cnt == 0) begin
         n_fail++;
         $display("FAIL low_sat_pulse: SAT high on %0d cycles, want at least 1", sat_cnt);
      end
   endtask

   task automatic test_high_sat();
      int sat_cnt, bad;
      go_integer(63);
      DSM_EN = 1'b1; NFRAC = 16'h0100;
      tick();
      sat_cnt = 0; bad = 0;
      for (int i = 0; i < 2000; i++) begin
         tick();
         if (i == 0) begin
            n_tests++;
            if (DIVNUM !== 6'd63 || SAT !== 1'b0) begin
               n_fail++;
               $display("FAIL high_sat_first: DIVNUM=%0d SAT=%b, want 63/0", DIVNUM, SAT);
            end
         end
         if (SAT === 1'b1) sat_cnt++;
         // delta >= -3, so anything below 60 or a SAT off the top is wrong.
         if (DIVNUM < 6'd60) bad++;
         if (SAT === 1'b1 && DIVNUM !== 6'd63) bad++;
         if (DIVNUM < 6'd63 && SAT !== 1'b0) bad++;
      end
      n_tests++;
      if (bad != 0) begin
         n_fail++;
         $display("FAIL high_sat_range: %0d bad cycles, want DIVNUM in 60..63 and SAT only at 63", bad);
      end
      n_tests++;
      if (sat_cnt == 0) begin
         n_fail++;
         $display("FAIL high_sat_pulse: SAT high on %0d cycles, want at least 1", sat_cnt);
      end
   endtask

   task automatic test_midrun_reset();
      int bad;
      go_integer(20);
      DSM_EN = 1'b1; NFRAC = 16'h4000;
      tick();
      for (int i = 0; i < 500; i++) tick();
      // DSM_EN stays high through reset: reset must win.
      RST = 1'b1;
      tick();
      n_tests++;
      if (DIVNUM !== 6'd4 || SAT !== 1'b0) begin
         n_fail++;
         $display("FAIL midrun_reset: DIVNUM=%0d SAT=%b, want 4/0", DIVNUM, SAT);
      end
      tick();
      RST = 1'b0;
      tick();
      n_tests++;
      if (DIVNUM !== 6'd4 || SAT !== 1'b1) begin
         n_fail++;
         $display("FAIL midrun_rel1: DIVNUM=%0d SAT=%b, want 4/1", DIVNUM, SAT);
      end
      bad = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (int'(DIVNUM) != exp_quarter[i]) bad++;
      end
      n_tests++;
      if (bad != 0) begin
         n_fail++;
         $display("FAIL midrun_restart: %0d of 8 samples off the zero-state pattern, want 0", bad);
      end
   endtask

   task automatic test_half_dither();
      int sum, diff;
      go_integer(20);
      DSM_EN = 1'b1; NFRAC = 16'h8000;
      tick();
      sum = 0; diff = 0;
      for (int i = 0; i < 4096; i++) begin
         tick();
         sum += int'(DIVNUM);
         if (int'(DIVNUM) != exp_half[i % 4]) diff++;
      end
`ifdef MMD_DSM_DITHER_EN
      // 20.5 +/- 0.001 over 4096 cycles is 83968 +/- 4.
      n_tests++;
      if (sum < 83964 || sum > 83972) begin
         n_fail++;
         $display("FAIL dither_mean: sum=%0d, want 83968 +/- 4", sum);
      end
      n_tests++;
      if (diff == 0) begin
         n_fail++;
         $display("FAIL dither_differs: %0d cycles differ from undithered, want > 0", diff);
      end
`else
      n_tests++;
      if (sum != 83968) begin
         n_fail++;
         $display("FAIL half_sum: sum=%0d, want 83968", sum);
      end
      n_tests++;
      if (diff != 0) begin
         n_fail++;
         $display("FAIL half_pattern: %0d cycles off 20,22,19,21, want 0", diff);
      end
`endif
   endtask

   initial begin
      test_reset();
      test_integer();
      test_frac_mean();
      test_nfrac_zero();
      test_low_sat();
      test_high_sat();
      test_midrun_reset();
      test_half_dither();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
